// File: rtl/fcvt_w_s_if.sv
// Operand/result bundle for the float-to-integer converter.
// Handshake: a transfer happens on a rising clock edge where valid && ready;
// the producer holds its payload stable while valid is high and not yet taken.
interface fcvt_w_s_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [2:0]  rm;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [1:0]  flags;

  // Producer of operands and consumer of results (issue logic / bench).
  modport master (
    output in_valid, x, rm, is_unsigned, out_ready,
    input  in_ready, out_valid, y, flags
  );

  // The converter itself.
  modport slave (
    input  in_valid, x, rm, is_unsigned, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/fcvt_w_s.sv
// Two-stage binary32 -> int32/uint32 converter (fcvt.w.s / fcvt.wu.s).
// Stage 1 aligns the significand to an integer plus guard/sticky bits,
// stage 2 rounds, saturates and raises {NV, NX}.
module fcvt_w_s (
  input  logic        clk,
  input  logic        rstn,
  fcvt_w_s_if.slave   bus
);

  // Whole pipe advances together; stalls only when the result is unclaimed.
  logic en;
  logic v1;
  logic v2;

  assign en           = !v2 || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = v2;

  // ---------------- stage 1: unpack and align ----------------
  logic        s0;
  logic [7:0]  e0;
  logic [22:0] f0;
  logic [23:0] m0;
  logic [7:0]  dl;
  logic [7:0]  dr;
  logic [47:0] ext;
  logic [32:0] int0;
  logic        g0;
  logic        st0;
  logic        nan0;
  logic        inf0;
  logic        big0;

  // Align the significand: left shift for e >= 150, right shift with
  // guard/sticky extraction for 126..149, pure sticky below that.
  always_comb begin
    s0   = bus.x[31];
    e0   = bus.x[30:23];
    f0   = bus.x[22:0];
    m0   = (e0 == 8'd0) ? 24'd0 : {1'b1, f0};
    dl   = e0 - 8'd150;
    dr   = 8'd150 - e0;
    ext  = {m0, 24'd0} >> dr;
    int0 = '0;
    g0   = 1'b0;
    st0  = 1'b0;
    if (e0 >= 8'd150) begin
      // Only meaningful up to e = 158; larger exponents take the big path.
      int0 = {9'd0, m0} << dl;
    end else if (e0 >= 8'd126) begin
      int0 = {9'd0, ext[47:24]};
      g0   = ext[23];
      st0  = |ext[22:0];
    end else begin
      st0 = (e0 != 8'd0) || (f0 != 23'd0);
    end
    nan0 = (e0 == 8'hFF) && (f0 != 23'd0);
    inf0 = (e0 == 8'hFF) && (f0 == 23'd0);
    big0 = (e0 >= 8'd159);
  end

  logic        s1;
  logic [2:0]  rm1;
  logic        uns1;
  logic [32:0] int1;
  logic        g1;
  logic        st1;
  logic        nan1;
  logic        inf1;
  logic        big1;

  // Stage 1 valid bit; cleared by reset so in-flight work is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1 <= bus.in_valid;
    end
  end

  // Stage 1 payload; contents only matter while v1 is set.
  always_ff @(posedge clk) begin
    if (en) begin
      s1   <= s0;
      rm1  <= bus.rm;
      uns1 <= bus.is_unsigned;
      int1 <= int0;
      g1   <= g0;
      st1  <= st0;
      nan1 <= nan0;
      inf1 <= inf0;
      big1 <= big0;
    end
  end

  // ---------------- stage 2: round and saturate ----------------
  logic        inc;
  logic [32:0] mag;
  logic [31:0] y_n;
  logic        nv;
  logic        nx;

  // Rounding increment, integer magnitude, and saturation per signedness.
  always_comb begin
    case (rm1)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s1 && (g1 || st1);
      3'b011:  inc = !s1 && (g1 || st1);
      3'b100:  inc = g1;
      default: inc = g1 && (st1 || int1[0]);
    endcase
    mag = int1 + {32'd0, inc};
    y_n = 32'd0;
    nv  = 1'b0;
    if (!uns1) begin
      if (nan1 || (!s1 && (inf1 || big1 || mag[32] || mag[31]))) begin
        y_n = 32'h7FFF_FFFF;
        nv  = 1'b1;
      end else if (s1 && (inf1 || big1 || mag[32] || (mag[31] && (|mag[30:0])))) begin
        y_n = 32'h8000_0000;
        nv  = 1'b1;
      end else begin
        y_n = s1 ? (32'd0 - mag[31:0]) : mag[31:0];
      end
    end else begin
      if (nan1 || (!s1 && (inf1 || big1 || mag[32]))) begin
        y_n = 32'hFFFF_FFFF;
        nv  = 1'b1;
      end else if (s1 && (inf1 || big1 || (mag != 33'd0))) begin
        y_n = 32'd0;
        nv  = 1'b1;
      end else begin
        y_n = s1 ? 32'd0 : mag[31:0];
      end
    end
    nx = !nv && (g1 || st1);
  end

  // Output register: holds during a stall, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2        <= 1'b0;
      bus.y     <= 32'd0;
      bus.flags <= 2'b00;
    end else if (en) begin
      v2        <= v1;
      bus.y     <= y_n;
      bus.flags <= {nv, nx};
    end
  end

endmodule
